// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-memory, redirect and decode-handshake signals of fetch_ctrl
interface fetch_ctrl_if;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_insn;
   logic [7:0]  dec_pc;
   logic [1:0]  buf_count;
   logic        halted;
   logic        misalign;
   modport master (
      output imem_addr,
      input  imem_rdata,
      input  stall,
      input  redirect_valid,
      input  redirect_pc,
      output dec_valid,
      input  dec_ready,
      output dec_insn,
      output dec_pc,
      output buf_count,
      output halted,
      output misalign
   );
   modport slave (
      input  imem_addr,
      output imem_rdata,
      output stall,
      output redirect_valid,
      output redirect_pc,
      input  dec_valid,
      output dec_ready,
      input  dec_insn,
      input  dec_pc,
      input  buf_count,
      input  halted,
      input  misalign
   );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer feeding a 2-entry decode buffer with redirect and halt; FETCH_HALT_EN enables halting on an all-zero word
module fetch_ctrl #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input logic          clk,
   input logic          rst_n,
   fetch_ctrl_if.master bus
);
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
   state_t      state_q, state_d;
   logic [7:0]  pc_q, pc_d, pc0_q, pc0_d, pc1_q, pc1_d;
   logic [31:0] insn0_q, insn0_d, insn1_q, insn1_d;
   logic [1:0]  count_q, count_d;
   logic        valid_q, misalign_q, halted_q;
   logic        deq, fetch, zero_word, enq, to_tail;
   // Fetch/dequeue decisions, buffer movement and next PC/state; redirect overrides all of it
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      count_d = count_q;
      insn0_d = insn0_q;
      pc0_d   = pc0_q;
      insn1_d = insn1_q;
      pc1_d   = pc1_q;
      deq     = valid_q && bus.dec_ready;
      fetch   = state_q == RUN && !bus.stall && !bus.redirect_valid && (count_q != 2'd2 || deq);
`ifdef FETCH_HALT_EN
      zero_word = bus.imem_rdata == 32'h0;
`else
      zero_word = 1'b0;
`endif
      enq     = fetch && !zero_word;
      to_tail = count_q == 2'd2 || (count_q == 2'd1 && !deq);
      if (bus.redirect_valid) begin
         state_d = RUN;
         pc_d    = {bus.redirect_pc[7:2], 2'b00};
         count_d = 2'd0;
      end else begin
         if (state_q == IDLE) state_d = RUN;
         if (fetch && zero_word) state_d = HALT;
         if (deq && count_q == 2'd2) begin
            insn0_d = insn1_q;
            pc0_d   = pc1_q;
         end
         if (enq) begin
            pc_d = pc_q + 8'd4;
            if (to_tail) begin
               insn1_d = bus.imem_rdata;
               pc1_d   = pc_q;
            end else begin
               insn0_d = bus.imem_rdata;
               pc0_d   = pc_q;
            end
         end
         count_d = (enq && !deq) ? count_q + 2'd1 : (deq && !enq) ? count_q - 2'd1 : count_q;
      end
   end
   // State, PC and buffer registers; every output is taken straight from a register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         count_q    <= 2'd0;
         insn0_q    <= 32'h0;
         pc0_q      <= 8'h0;
         insn1_q    <= 32'h0;
         pc1_q      <= 8'h0;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         count_q    <= count_d;
         insn0_q    <= insn0_d;
         pc0_q      <= pc0_d;
         insn1_q    <= insn1_d;
         pc1_q      <= pc1_d;
         valid_q    <= count_d != 2'd0;
         misalign_q <= bus.redirect_valid && bus.redirect_pc[1:0] != 2'b00;
         halted_q   <= state_d == HALT;
      end
   end
   assign bus.imem_addr = pc_q;
   assign bus.dec_valid = valid_q;
   assign bus.dec_insn  = insn0_q;
   assign bus.dec_pc    = pc0_q;
   assign bus.buf_count = count_q;
   assign bus.halted    = halted_q;
   assign bus.misalign  = misalign_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized scoreboard bench for fetch_ctrl against a queue-based reference model
module tb_fetch_ctrl;
   localparam logic [7:0] RPC = 8'h00;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] mem [64];
   logic [39:0] q[$];
   logic [39:0] last_head;
   logic [7:0]  m_pc;
   int          mode;
   logic        m_mis;
   logic        mon_en = 1'b0;
   logic        p_rst, p_redir, p_fetch;
   logic [7:0]  p_rpc;
   int          n_cmp = 0;
   int          n_bad = 0;
   fetch_ctrl_if bus();
   fetch_ctrl #(.RESET_PC(RPC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   assign bus.imem_rdata = mem[bus.imem_addr[7:2]];
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   // Monitor: compare every visible output with the model and pop the scoreboard on a handshake
   always @(negedge clk) begin
      if (mon_en) begin
         if (q.size() != 0) last_head = q[0];
         check("buf_count", 32'(bus.buf_count), 32'(q.size()));
         check("dec_valid", 32'(bus.dec_valid), 32'(q.size() != 0));
         check("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
         check("halted", 32'(bus.halted), 32'(mode == 2));
         check("misalign", 32'(bus.misalign), 32'(m_mis));
         check("dec_insn", bus.dec_insn, last_head[39:8]);
         check("dec_pc", 32'(bus.dec_pc), 32'(last_head[7:0]));
         if (bus.dec_valid && bus.dec_ready && q.size() != 0) void'(q.pop_front());
      end
   end
   task automatic apply_pending();
      logic [31:0] w;
      if (p_rst) begin
         q.delete();
         m_pc = RPC;
         mode = 0;
         m_mis = 1'b0;
         last_head = 40'h0;
      end else if (p_redir) begin
         q.delete();
         m_pc = {p_rpc[7:2], 2'b00};
         mode = 1;
         m_mis = p_rpc[1:0] != 2'b00;
      end else begin
         m_mis = 1'b0;
         if (mode == 0) mode = 1;
         else if (p_fetch) begin
            w = mem[m_pc[7:2]];
`ifdef FETCH_HALT_EN
            if (w == 32'h0) mode = 2;
            else begin
               q.push_back({w, m_pc});
               m_pc = m_pc + 8'd4;
            end
`else
            q.push_back({w, m_pc});
            m_pc = m_pc + 8'd4;
`endif
         end
      end
   endtask
   initial begin
      int prof;
      for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
      mem[3]  = 32'h0;
      mem[40] = 32'h0;
      bus.stall = 1'b0;
      bus.dec_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 8'h0;
      p_rst = 1'b1;
      p_redir = 1'b0;
      p_fetch = 1'b0;
      p_rpc = 8'h0;
      last_head = 40'h0;
      m_pc = RPC;
      mode = 0;
      m_mis = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk);
         #1;
         apply_pending();
         mon_en = 1'b1;
         prof = (cyc / 250) % 4;
         rst_n = !(cyc < 2 || cyc == 1500 || $urandom_range(0, 599) == 0);
         bus.dec_ready = prof == 0 ? 1'b1 : prof == 1 ? $urandom_range(0, 9) < 3 : $urandom_range(0, 9) < 7;
         bus.stall = prof == 2 ? $urandom_range(0, 9) < 4 : 1'b0;
         bus.redirect_valid = prof == 3 ? $urandom_range(0, 9) == 0 :
                              mode == 2 ? $urandom_range(0, 9) < 2 : $urandom_range(0, 99) == 0;
         bus.redirect_pc = $urandom_range(0, 3) == 0 ? 8'hF0 | 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
         p_rst = !rst_n;
         p_redir = bus.redirect_valid;
         p_rpc = bus.redirect_pc;
         p_fetch = mode == 1 && !bus.stall && !bus.redirect_valid &&
                   (q.size() < 2 || (q.size() != 0 && bus.dec_ready));
      end
      @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
